slc3_run_ctrl: RTL and testbench

//  Run/Continue sequencer for the SLC-3 CPU. Takes the raw active-low Run and Continue pushbuttons
//  and conditions each one through a synchronizer and a debouncer.

---
 rtl/slc3_run_ctrl.sv | 148 ++++++++++++++
 tb/tb_slc3_run_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slc3_run_ctrl.sv
// slc3_run_ctrl: Run/Continue button conditioning and the run/pause/step
// sequencer that gates the SLC-3 ISDU.
module slc3_run_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Continue,
    input  logic             step_mode,
    input  logic             cpu_fetch,
    input  logic             cpu_pause,
    output logic             cpu_en,
    output logic             cpu_init,
    output logic             cpu_continue,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        PREL  = 3'd3,
        HOLD  = 3'd4,
        STEP  = 3'd5
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_press;
    logic       w_run_p;
    logic       w_cont_p;
    logic       w_fetch_edge;
    state_t     w_next;

    state_t           r_state;
    logic             r_en;
    logic             r_init;
    logic             r_cont;
    logic             r_fetch_q;
    logic [CNT_W-1:0] r_ic;

    assign w_raw = {Continue, Run};

    // Bit 0 conditions Run, bit 1 conditions Continue.
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [SYNC_STAGES-1:0] r_sync;
        logic [DB_W-1:0]        r_cnt;
        logic                   r_lvl;
        logic                   r_press;
        logic                   w_sync;

        assign w_sync     = r_sync[SYNC_STAGES-1];
        assign w_press[b] = r_press;

        always_ff @(posedge Clk) begin
            if (!Reset) begin
                r_sync  <= '1;
                r_cnt   <= '0;
                r_lvl   <= 1'b1;
                r_press <= 1'b0;
            end else begin
                r_sync  <= {r_sync[SYNC_STAGES-2:0], w_raw[b]};
                r_press <= 1'b0;
                if (w_sync == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_cnt   <= '0;
                    r_lvl   <= w_sync;
                    r_press <= ~w_sync;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign w_run_p      = w_press[0];
    assign w_cont_p     = w_press[1];
    assign w_fetch_edge = cpu_fetch & ~r_fetch_q;

    always_comb begin
        w_next = r_state;
        if (w_run_p) begin
            w_next = RUN;
        end else begin
            case (r_state)
                IDLE:  w_next = IDLE;
                RUN: begin
                    if (cpu_pause)
                        w_next = PAUSE;
                    else if (w_fetch_edge && step_mode)
                        w_next = HOLD;
                end
                PAUSE: if (w_cont_p) w_next = PREL;
                PREL:  if (!cpu_pause) w_next = RUN;
                HOLD: begin
                    if (w_cont_p)
                        w_next = step_mode ? STEP : RUN;
                end
                STEP: begin
                    if (cpu_pause)
                        w_next = PAUSE;
                    else if (w_fetch_edge)
                        w_next = HOLD;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // cpu_en is registered from the next state so it always matches state.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_en      <= 1'b0;
            r_init    <= 1'b0;
            r_cont    <= 1'b0;
            r_fetch_q <= 1'b0;
            r_ic      <= '0;
        end else begin
            r_state   <= w_next;
            r_en      <= (w_next inside {RUN, PAUSE, PREL, STEP});
            r_init    <= w_run_p;
            r_fetch_q <= cpu_fetch;
            if (w_run_p)
                r_cont <= 1'b0;
            else if (r_state == PAUSE && w_cont_p)
                r_cont <= 1'b1;
            else if (r_state == PREL && !cpu_pause)
                r_cont <= 1'b0;
            if (w_run_p)
                r_ic <= '0;
            else if (w_fetch_edge && r_en)
                r_ic <= r_ic + 1'b1;
        end
    end

    assign cpu_en       = r_en;
    assign cpu_init     = r_init;
    assign cpu_continue = r_cont;
    assign state        = r_state;
    assign instr_count  = r_ic;

endmodule

// File: tb/tb_slc3_run_ctrl.sv
// tb_slc3_run_ctrl: directed vector table plus randomized buttons/fetch/pause
// checked every cycle against a behavioural model of the sequencer.
module tb_slc3_run_ctrl;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int CW   = 16;
    localparam int HL   = 8;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_PREL  = 3;
    localparam int S_HOLD  = 4;
    localparam int S_STEP  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic run   = 1'b1;
    logic cont  = 1'b1;
    logic step  = 1'b0;
    logic fetch = 1'b0;
    logic pause = 1'b0;

    logic          en;
    logic          init;
    logic          cpc;
    logic [2:0]    st;
    logic [CW-1:0] cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    slc3_run_ctrl #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .Clk         (clk),
        .Reset       (rst_n),
        .Run         (run),
        .Continue    (cont),
        .step_mode   (step),
        .cpu_fetch   (fetch),
        .cpu_pause   (pause),
        .cpu_en      (en),
        .cpu_init    (init),
        .cpu_continue(cpc),
        .state       (st),
        .instr_count (cnt)
    );

    // Behavioural model: raw sample history per button, level flips when the
    // last DEB synchronized samples all disagree with it.
    int m_st;
    bit m_en, m_init, m_cont, m_fq;
    int m_cnt;
    bit m_lvl [2];
    bit m_pr  [2];
    bit h     [2][HL];

    task automatic m_step();
        bit fe;
        bit all;
        bit raw [2];
        int nx;
        if (!rst_n) begin
            m_st = S_IDLE; m_en = 0; m_init = 0; m_cont = 0;
            m_cnt = 0; m_fq = 0;
            for (int b = 0; b < 2; b++) begin
                m_lvl[b] = 1;
                m_pr[b]  = 0;
                for (int k = 0; k < HL; k++) h[b][k] = 1;
            end
            return;
        end
        raw[0] = run;
        raw[1] = cont;
        fe = fetch && !m_fq;
        nx = m_st;
        if (fe && m_en) m_cnt = (m_cnt + 1) % (1 << CW);
        m_init = m_pr[0];
        if (m_pr[0]) begin
            nx = S_RUN; m_cnt = 0; m_cont = 0;
        end else begin
            case (m_st)
                S_IDLE: nx = S_IDLE;
                S_RUN: begin
                    if (pause) nx = S_PAUSE;
                    else if (fe && step) nx = S_HOLD;
                end
                S_PAUSE: begin
                    if (m_pr[1]) begin nx = S_PREL; m_cont = 1; end
                end
                S_PREL: begin
                    if (!pause) begin nx = S_RUN; m_cont = 0; end
                end
                S_HOLD: begin
                    if (m_pr[1]) nx = step ? S_STEP : S_RUN;
                end
                S_STEP: begin
                    if (pause) nx = S_PAUSE;
                    else if (fe) nx = S_HOLD;
                end
                default: nx = S_IDLE;
            endcase
        end
        m_st = nx;
        m_en = (nx == S_RUN || nx == S_PAUSE || nx == S_PREL || nx == S_STEP);
        m_fq = fetch;
        for (int b = 0; b < 2; b++) begin
            all = 1;
            for (int k = SYNC - 1; k < SYNC - 1 + DEB; k++)
                if (h[b][k] == m_lvl[b]) all = 0;
            m_pr[b] = 0;
            if (all) begin
                m_lvl[b] = !m_lvl[b];
                m_pr[b]  = !m_lvl[b];
            end
            for (int k = HL - 1; k > 0; k--) h[b][k] = h[b][k-1];
            h[b][0] = raw[b];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            m_step();
        end
    end

    initial begin
        logic [CW+5:0] got, exp;
        @(posedge clk);
        forever begin
            @(negedge clk);
            got = {st, en, init, cpc, cnt};
            exp = {3'(m_st), m_en, m_init, m_cont, CW'(m_cnt)};
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL model t=%0t: got st=%0d en=%b init=%b cont=%b cnt=%0d, exp st=%0d en=%b init=%b cont=%b cnt=%0d",
                         $time, st, en, init, cpc, cnt,
                         m_st, m_en, m_init, m_cont, m_cnt);
            end
        end
    end

    typedef struct {
        int cyc;
        bit rs, rn, ct, sp, fe, pa;
        int est;
        bit een, ein, eco;
        int ecn;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(int cyc, bit rs, bit rn, bit ct, bit sp,
                                bit fe, bit pa, int est, bit een, bit ein,
                                bit eco, int ecn);
        vec_t v;
        v.cyc = cyc; v.rs = rs; v.rn = rn; v.ct = ct; v.sp = sp;
        v.fe = fe; v.pa = pa; v.est = est; v.een = een; v.ein = ein;
        v.eco = eco; v.ecn = ecn;
        return v;
    endfunction

    initial begin
        int rh, ch, ph;
        //            cyc rs rn ct sp fe pa  st en in co cnt
        tv.push_back(mk(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(6, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0));
        tv.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        tv.push_back(mk(8, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 0, 1, 2, 1, 0, 0, 0));
        tv.push_back(mk(7, 1, 1, 0, 0, 0, 1, 3, 1, 0, 1, 0));
        tv.push_back(mk(5, 1, 1, 1, 0, 0, 1, 3, 1, 0, 1, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        tv.push_back(mk(2, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0));
        tv.push_back(mk(1, 1, 1, 1, 1, 1, 0, 4, 0, 0, 0, 1));
        tv.push_back(mk(2, 1, 1, 1, 1, 1, 0, 4, 0, 0, 0, 1));
        tv.push_back(mk(7, 1, 1, 0, 1, 0, 0, 5, 1, 0, 0, 1));
        tv.push_back(mk(1, 1, 1, 1, 1, 1, 0, 4, 0, 0, 0, 2));
        tv.push_back(mk(6, 1, 1, 1, 1, 1, 0, 4, 0, 0, 0, 2));
        tv.push_back(mk(7, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 2));
        tv.push_back(mk(8, 1, 1, 1, 0, 1, 1, 2, 1, 0, 0, 2));
        tv.push_back(mk(7, 1, 1, 0, 0, 1, 1, 3, 1, 0, 1, 2));
        tv.push_back(mk(8, 1, 1, 1, 0, 1, 1, 3, 1, 0, 1, 2));
        tv.push_back(mk(7, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0));
        tv.push_back(mk(8, 1, 1, 1, 0, 1, 1, 2, 1, 0, 0, 0));
        tv.push_back(mk(7, 1, 1, 0, 0, 1, 1, 3, 1, 0, 1, 0));
        tv.push_back(mk(1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        tv.push_back(mk(2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(10, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(6, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0));
        tv.push_back(mk(8, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 1, 0, 1, 1, 0, 0, 1));
        tv.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1));
        tv.push_back(mk(6, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1));
        tv.push_back(mk(1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0));

        foreach (tv[i]) begin
            rst_n = tv[i].rs; run = tv[i].rn; cont = tv[i].ct;
            step = tv[i].sp; fetch = tv[i].fe; pause = tv[i].pa;
            repeat (tv[i].cyc) @(negedge clk);
            n_vec++;
            if (st !== 3'(tv[i].est) || en !== tv[i].een ||
                init !== tv[i].ein || cpc !== tv[i].eco ||
                cnt !== CW'(tv[i].ecn)) begin
                n_bad++;
                $display("FAIL row%0d: got st=%0d en=%b init=%b cont=%b cnt=%0d, exp st=%0d en=%b init=%b cont=%b cnt=%0d",
                         i, st, en, init, cpc, cnt, tv[i].est, tv[i].een,
                         tv[i].ein, tv[i].eco, tv[i].ecn);
            end
        end

        rh = 0; ch = 0; ph = 0;
        for (int c = 0; c < 4000; c++) begin
            if (rh == 0) begin
                run = ~run;
                rh = run ? $urandom_range(20, 150) : $urandom_range(1, 12);
            end
            rh--;
            if (ch == 0) begin
                cont = ~cont;
                ch = cont ? $urandom_range(3, 25) : $urandom_range(1, 12);
            end
            ch--;
            if (ph == 0) begin
                pause = ~pause;
                ph = $urandom_range(1, 15);
            end
            ph--;
            fetch = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) step = ~step;
            rst_n = ($urandom_range(0, 499) != 0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
